// File: rtl/viterbi_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : viterbi_stream_decoder
//  Description : Streaming Viterbi decoder for an I-state, K-symbol HMM.
//                Observations arrive over a valid/ready handshake, one ACS
//                step per accepted symbol (I parallel lanes). After the last
//                symbol the survivor memory is backtracked and the decoded
//                state path is streamed out in time order over valid/ready,
//                together with the best final log-score. All additions are
//                saturating in the W-bit signed log domain.
//  Ports       : clk, rst_n           clock / async active-low reset
//                start, length        decode request and sequence length L
//                logA, logC, logB     flattened model tables (static while busy)
//                obs_data/valid/ready observation stream
//                path_state/idx/valid/ready/last  decoded path stream
//                best_score           max final delta (held until next start)
//                busy                 high outside IDLE
//                err_len              one-cycle pulse on rejected length
//  Revision    : 1.0 - initial release
// ============================================================================
module viterbi_stream_decoder #(
  parameter int N = 16,
  parameter int I = 3,
  parameter int K = 3,
  parameter int W = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(N+1)-1:0]     length,
  input  logic [I*I*W-1:0]           logA,
  input  logic [I*W-1:0]             logC,
  input  logic [I*K*W-1:0]           logB,
  input  logic [$clog2(K)-1:0]       obs_data,
  input  logic                       obs_valid,
  output logic                       obs_ready,
  output logic [$clog2(I)-1:0]       path_state,
  output logic [$clog2(N)-1:0]       path_idx,
  output logic                       path_valid,
  input  logic                       path_ready,
  output logic                       path_last,
  output logic [W-1:0]               best_score,
  output logic                       busy,
  output logic                       err_len
);

  localparam int LW = $clog2(N+1);
  localparam int SW = $clog2(I);
  localparam int IW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_ACS  = 3'd2,
    S_BACK = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  // Saturating W-bit signed add: overflow shows as disagreement of the two
  // top bits of the W+1-bit sum; clamp toward the sign of the true result.
  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         t_q, t_d;
  logic [LW-1:0]         b_q, b_d;
  logic                  back_first_q, back_first_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [W-1:0]   best_q, best_d;
  logic                  err_q, err_d;
  logic signed [W-1:0]   delta_q [I];
  logic signed [W-1:0]   delta_d [I];
  logic [SW-1:0]         psi_q   [N][I];
  logic [SW-1:0]         psi_d   [N][I];
  logic [SW-1:0]         pbuf_q  [N];
  logic [SW-1:0]         pbuf_d  [N];

  // --------------------------------------------------------------------------
  // Table unpacking
  // --------------------------------------------------------------------------
  logic signed [W-1:0]   loga_w [I][I];
  logic signed [W-1:0]   logb_w [I][K];
  logic signed [W-1:0]   logc_w [I];

  generate
    for (genvar gi = 0; gi < I; gi++) begin : g_unpack_i
      assign logc_w[gi] = logC[gi*W +: W];
      for (genvar gj = 0; gj < I; gj++) begin : g_unpack_a
        assign loga_w[gi][gj] = logA[(gi*I+gj)*W +: W];
      end
      for (genvar gk = 0; gk < K; gk++) begin : g_unpack_b
        assign logb_w[gi][gk] = logB[(gi*K+gk)*W +: W];
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // ACS lanes: one per destination state i
  // --------------------------------------------------------------------------
  logic signed [W-1:0]   emis_w       [I];
  logic signed [W-1:0]   init_delta_w [I];
  logic signed [W-1:0]   acs_delta_w  [I];
  logic [SW-1:0]         acs_psi_w    [I];

  generate
    for (genvar gi = 0; gi < I; gi++) begin : g_acs
      logic signed [W-1:0] best_v;
      logic signed [W-1:0] cand_v;
      logic [SW-1:0]       arg_v;

      assign emis_w[gi]       = logb_w[gi][obs_data];
      assign init_delta_w[gi] = sat_add(logc_w[gi], emis_w[gi]);

      // Strict '>' keeps the lowest predecessor index on ties.
      always_comb begin
        best_v = sat_add(delta_q[0], loga_w[0][gi]);
        arg_v  = '0;
        cand_v = best_v;
        for (int j = 1; j < I; j++) begin
          cand_v = sat_add(delta_q[j], loga_w[j][gi]);
          if (cand_v > best_v) begin
            best_v = cand_v;
            arg_v  = SW'(j);
          end
        end
      end

      assign acs_delta_w[gi] = sat_add(best_v, emis_w[gi]);
      assign acs_psi_w[gi]   = arg_v;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Final argmax over delta (lowest index wins ties)
  // --------------------------------------------------------------------------
  logic signed [W-1:0]   fin_max_w;
  logic [SW-1:0]         fin_arg_w;

  always_comb begin
    fin_max_w = delta_q[0];
    fin_arg_w = '0;
    for (int j = 1; j < I; j++) begin
      if (delta_q[j] > fin_max_w) begin
        fin_max_w = delta_q[j];
        fin_arg_w = SW'(j);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control / datapath next-state
  // --------------------------------------------------------------------------
  logic [LW-1:0]         lm1_w;
  logic [LW-1:0]         bm1_w;
  logic                  obs_ready_w;
  logic                  len_bad_w;

  assign lm1_w     = len_q - 1'b1;
  assign bm1_w     = b_q - 1'b1;
  assign len_bad_w = (length == '0) || (length > LW'(N));

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    t_d          = t_q;
    b_d          = b_q;
    back_first_d = back_first_q;
    idx_d        = idx_q;
    best_d       = best_q;
    err_d        = 1'b0;
    delta_d      = delta_q;
    psi_d        = psi_q;
    pbuf_d       = pbuf_q;
    obs_ready_w  = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) begin
          if (len_bad_w) begin
            err_d = 1'b1;
          end else begin
            len_d   = length;
            state_d = S_INIT;
          end
        end
      end

      S_INIT: begin
        obs_ready_w = 1'b1;
        if (obs_valid) begin
          delta_d      = init_delta_w;
          t_d          = LW'(1);
          back_first_d = 1'b1;
          state_d      = (len_q > LW'(1)) ? S_ACS : S_BACK;
        end
      end

      S_ACS: begin
        obs_ready_w = 1'b1;
        if (obs_valid) begin
          delta_d = acs_delta_w;
          for (int i = 0; i < I; i++) begin
            psi_d[t_q[IW-1:0]][i] = acs_psi_w[i];
          end
          t_d = t_q + 1'b1;
          if (t_q == lm1_w) begin
            back_first_d = 1'b1;
            state_d      = S_BACK;
          end
        end
      end

      S_BACK: begin
        if (back_first_q) begin
          // Seed the traceback with the best terminal state.
          best_d                   = fin_max_w;
          pbuf_d[lm1_w[IW-1:0]]    = fin_arg_w;
          b_d                      = lm1_w;
          back_first_d             = 1'b0;
          if (len_q == LW'(1)) begin
            idx_d   = '0;
            state_d = S_EMIT;
          end
        end else begin
          pbuf_d[bm1_w[IW-1:0]] = psi_q[b_q[IW-1:0]][pbuf_q[b_q[IW-1:0]]];
          b_d                   = bm1_w;
          if (b_q == LW'(1)) begin
            idx_d   = '0;
            state_d = S_EMIT;
          end
        end
      end

      S_EMIT: begin
        if (path_ready) begin
          if (idx_q == lm1_w[IW-1:0]) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      t_q          <= '0;
      b_q          <= '0;
      back_first_q <= 1'b0;
      idx_q        <= '0;
      best_q       <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < I; i++) begin
        delta_q[i] <= '0;
      end
      for (int n = 0; n < N; n++) begin
        pbuf_q[n] <= '0;
        for (int i = 0; i < I; i++) begin
          psi_q[n][i] <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      t_q          <= t_d;
      b_q          <= b_d;
      back_first_q <= back_first_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      err_q        <= err_d;
      delta_q      <= delta_d;
      psi_q        <= psi_d;
      pbuf_q       <= pbuf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign obs_ready  = obs_ready_w;
  assign path_valid = (state_q == S_EMIT);
  assign path_idx   = idx_q;
  assign path_state = path_valid ? pbuf_q[idx_q] : '0;
  assign path_last  = path_valid && (idx_q == lm1_w[IW-1:0]);
  assign best_score = best_q;
  assign busy       = (state_q != S_IDLE);
  assign err_len    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_viterbi_stream_decoder
//  Description : Self-checking bench for viterbi_stream_decoder (N=16, I=3,
//                K=3, W=20). A reference Viterbi model produces the expected
//                path for each sequence; beats are queued when the last
//                observation is driven and compared as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_viterbi_stream_decoder;

  localparam int N    = 16;
  localparam int I    = 3;
  localparam int K    = 3;
  localparam int W    = 20;
  localparam int SMIN = -524288;
  localparam int SMAX = 524287;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [4:0]        length;
  logic [I*I*W-1:0]  logA;
  logic [I*W-1:0]    logC;
  logic [I*K*W-1:0]  logB;
  logic [1:0]        obs_data;
  logic              obs_valid;
  logic              obs_ready;
  logic [1:0]        path_state;
  logic [3:0]        path_idx;
  logic              path_valid;
  logic              path_ready;
  logic              path_last;
  logic [W-1:0]      best_score;
  logic              busy;
  logic              err_len;

  viterbi_stream_decoder #(.N(N), .I(I), .K(K), .W(W)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .length     (length),
    .logA       (logA),
    .logC       (logC),
    .logB       (logB),
    .obs_data   (obs_data),
    .obs_valid  (obs_valid),
    .obs_ready  (obs_ready),
    .path_state (path_state),
    .path_idx   (path_idx),
    .path_valid (path_valid),
    .path_ready (path_ready),
    .path_last  (path_last),
    .best_score (best_score),
    .busy       (busy),
    .err_len    (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model tables
  int ma [I][I];
  int mb [I][K];
  int mc [I];

  typedef struct {
    int st;
    int idx;
    int last;
    int best;
  } beat_t;

  beat_t exp_q [$];
  bit    stall_en = 1'b0;

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  task automatic pack_cfg();
    int v;
    for (int i = 0; i < I; i++) begin
      v = mc[i];
      logC[i*W +: W] = v[W-1:0];
      for (int j = 0; j < I; j++) begin
        v = ma[i][j];
        logA[(i*I+j)*W +: W] = v[W-1:0];
      end
      for (int k = 0; k < K; k++) begin
        v = mb[i][k];
        logB[(i*K+k)*W +: W] = v[W-1:0];
      end
    end
  endtask

  // Reference Viterbi decode with lowest-index tie-break.
  task automatic model(input int L, input int ob [N], output int p [N], output int best);
    longint d [I];
    longint nd [I];
    longint bst, c;
    int     ps [N][I];
    int     arg;
    for (int i = 0; i < I; i++) d[i] = sat(longint'(mc[i]) + mb[i][ob[0]]);
    for (int t = 1; t < L; t++) begin
      for (int i = 0; i < I; i++) begin
        bst = sat(d[0] + ma[0][i]);
        arg = 0;
        for (int j = 1; j < I; j++) begin
          c = sat(d[j] + ma[j][i]);
          if (c > bst) begin bst = c; arg = j; end
        end
        nd[i]     = sat(bst + mb[i][ob[t]]);
        ps[t][i]  = arg;
      end
      for (int i = 0; i < I; i++) d[i] = nd[i];
    end
    bst = d[0];
    arg = 0;
    for (int j = 1; j < I; j++) if (d[j] > bst) begin bst = d[j]; arg = j; end
    best     = int'(bst);
    p[L-1]   = arg;
    for (int t = L-1; t >= 1; t--) p[t-1] = ps[t][p[t]];
  endtask

  // Path monitor: drives path_ready, checks beats and stall stability.
  initial begin
    bit    prev_stall;
    int    s_st, s_idx, s_last;
    beat_t e;
    prev_stall = 1'b0;
    path_ready = 1'b0;
    s_st = 0; s_idx = 0; s_last = 0;
    forever begin
      @(negedge clk);
      path_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else if (path_valid) begin
        if (prev_stall) begin
          chk_eq("stall_state", int'(path_state), s_st);
          chk_eq("stall_idx",   int'(path_idx),   s_idx);
          chk_eq("stall_last",  int'(path_last),  s_last);
        end
        if (path_ready) begin
          if (exp_q.size() == 0) begin
            chk_eq("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk_eq("path_state", int'(path_state), e.st);
            chk_eq("path_idx",   int'(path_idx),   e.idx);
            chk_eq("path_last",  int'(path_last),  e.last);
            chk_eq("best_score", int'($signed(best_score)), e.best);
          end
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          s_st   = int'(path_state);
          s_idx  = int'(path_idx);
          s_last = int'(path_last);
        end
      end else begin
        if (prev_stall) chk_eq("valid_dropped", 0, 1);
        prev_stall = 1'b0;
      end
    end
  end

  task automatic drive_start(input int L);
    @(negedge clk);
    length = 5'(L);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Feeds L observations; returns at the negedge after the last handshake.
  task automatic drive_obs(input int L, input int ob [N], input bit gaps, output bit ok);
    bit hs;
    int guard;
    ok = 1'b1;
    for (int t = 0; t < L; t++) begin
      hs    = 1'b0;
      guard = 0;
      while (!hs && ok) begin
        obs_data  = 2'(ob[t]);
        obs_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        hs = obs_valid && obs_ready;
        @(negedge clk);
        guard++;
        if (guard > 200) begin
          chk_eq("obs_timeout", 1, 0);
          ok = 1'b0;
        end
      end
      if (!ok) break;
    end
    obs_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 3000) begin
      @(negedge clk);
      g++;
    end
    #2;
    chk_eq("done_timeout", int'(busy), 0);
    chk_eq("beats_left", exp_q.size(), 0);
  endtask

  task automatic run_decode(input int L, input int ob [N], input bit gaps, input bit stalls,
                            input bit use_exp, input int exp_best);
    int    p [N];
    int    best;
    bit    ok;
    beat_t e;
    stall_en = stalls;
    drive_start(L);
    #1;
    chk_eq("busy_after_start", int'(busy), 1);
    drive_obs(L, ob, gaps, ok);
    model(L, ob, p, best);
    for (int t = 0; t < L; t++) begin
      e.st   = p[t];
      e.idx  = t;
      e.last = (t == L-1) ? 1 : 0;
      e.best = best;
      exp_q.push_back(e);
    end
    wait_idle();
    if (use_exp) chk_eq("best_final", int'($signed(best_score)), exp_best);
    stall_en = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk_eq("rst_obs_ready",  int'(obs_ready),  0);
    chk_eq("rst_path_valid", int'(path_valid), 0);
    chk_eq("rst_path_last",  int'(path_last),  0);
    chk_eq("rst_path_state", int'(path_state), 0);
    chk_eq("rst_path_idx",   int'(path_idx),   0);
    chk_eq("rst_best_score", int'($signed(best_score)), 0);
    chk_eq("rst_busy",       int'(busy),       0);
    chk_eq("rst_err_len",    int'(err_len),    0);
  endtask

  task automatic cfg_diag();
    for (int i = 0; i < I; i++) begin
      mc[i] = 0;
      for (int j = 0; j < I; j++) ma[i][j] = (i == j) ? 0 : -8;
      for (int k = 0; k < K; k++) mb[i][k] = (i == k) ? 0 : -8;
    end
    pack_cfg();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ob [N];
    bit  ok;
    rst_n     = 1'b0;
    start     = 1'b0;
    length    = '0;
    obs_data  = '0;
    obs_valid = 1'b0;
    logA = '0; logB = '0; logC = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Diagonal-dominant model, L=5
    cfg_diag();
    ob = '{default: 0};
    ob[0] = 0; ob[1] = 0; ob[2] = 1; ob[3] = 1; ob[4] = 2;
    run_decode(5, ob, 1'b0, 1'b0, 1'b1, -16);

    // Single-symbol sequence
    ob = '{default: 0};
    ob[0] = 2;
    run_decode(1, ob, 1'b0, 1'b0, 1'b1, 0);

    // All-zero tables: every comparison ties, path is all zeros
    for (int i = 0; i < I; i++) begin
      mc[i] = 0;
      for (int j = 0; j < I; j++) ma[i][j] = 0;
      for (int k = 0; k < K; k++) mb[i][k] = 0;
    end
    pack_cfg();
    ob = '{default: 0};
    ob[0] = 1; ob[1] = 2; ob[2] = 0; ob[3] = 1;
    run_decode(4, ob, 1'b0, 1'b0, 1'b1, 0);

    // Saturation at the negative rail
    for (int i = 0; i < I; i++) begin
      mc[i] = SMIN;
      for (int k = 0; k < K; k++) mb[i][k] = SMIN;
    end
    pack_cfg();
    ob = '{default: 0};
    ob[0] = 0; ob[1] = 1; ob[2] = 2;
    run_decode(3, ob, 1'b0, 1'b0, 1'b1, SMIN);

    // Random tables, full length, with observation gaps and output stalls
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < I; i++) begin
        mc[i] = -int'($urandom_range(0, 40));
        for (int j = 0; j < I; j++) ma[i][j] = -int'($urandom_range(0, 40));
        for (int k = 0; k < K; k++) mb[i][k] = -int'($urandom_range(0, 40));
      end
      pack_cfg();
      for (int t = 0; t < N; t++) ob[t] = int'($urandom_range(0, 2));
      run_decode(N, ob, 1'b1, 1'b1, 1'b0, 0);
    end

    // Rejected lengths
    drive_start(0);
    #1;
    chk_eq("err_len_l0", int'(err_len), 1);
    chk_eq("busy_l0", int'(busy), 0);
    @(negedge clk);
    #1;
    chk_eq("err_len_l0_clear", int'(err_len), 0);
    drive_start(17);
    #1;
    chk_eq("err_len_l17", int'(err_len), 1);
    chk_eq("busy_l17", int'(busy), 0);
    @(negedge clk);
    #1;
    chk_eq("err_len_l17_clear", int'(err_len), 0);

    // Reset asserted mid-ACS, then a clean decode
    cfg_diag();
    ob = '{default: 0};
    ob[0] = 0; ob[1] = 1; ob[2] = 2;
    drive_start(5);
    drive_obs(3, ob, 1'b0, ok);
    #1;
    chk_eq("busy_mid_acs", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ob = '{default: 0};
    ob[0] = 2; ob[1] = 2; ob[2] = 1; ob[3] = 0; ob[4] = 0; ob[5] = 1;
    run_decode(6, ob, 1'b0, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
